note_cmd_sequencer: RTL and testbench

//  Upstream stage of the tone/envelope voice path. Pops 32-bit command words from the

---
 rtl/note_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_note_cmd_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_cmd_sequencer.sv
// Command sequencer for the voice path: pops FIFO words, drives period/gain/gate and envelope strobes.
// Latency: outputs update on the edge leaving EXEC, 3 cycles after the pop cycle; at most 1 command per 3 cycles.
// Backpressure: pops only in IDLE with enable high and FIFO non-empty; WAIT and enable low hold off pops.
module note_cmd_sequencer #(
    parameter int TICK_DIV = 48000,
    parameter int PERIOD_W = 23,
    parameter int WAIT_W   = 24
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                enable,
    input  logic                cmd_empty,
    output logic                cmd_rd_en,
    input  logic [31:0]         cmd_data,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          gain,
    output logic                note_on,
    output logic                note_off,
    output logic                gate,
    output logic                busy,
    output logic [7:0]          err_count
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_NOTE_ON  = 4'h1;
    localparam logic [3:0] OP_NOTE_OFF = 4'h2;
    localparam logic [3:0] OP_WAIT     = 4'h3;
    localparam logic [3:0] OP_SET_GAIN = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         cmd_reg;
    logic [WAIT_W-1:0]   tick_cnt;
    logic [PRE_W-1:0]    pre_cnt;
    logic                pre_wrap;
    logic                last_tick;
    logic [3:0]          op;
    logic [PERIOD_W-1:0] arg_period;
    logic [WAIT_W-1:0]   arg_ticks;
    logic                cmd_unused;

    assign op         = cmd_reg[31:28];
    assign arg_period = cmd_reg[PERIOD_W-1:0];
    assign arg_ticks  = cmd_reg[WAIT_W-1:0];
    // Argument bits beyond the decoded fields are reserved and ignored.
    assign cmd_unused = ^cmd_reg;

    assign pre_wrap  = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign last_tick = (tick_cnt == WAIT_W'(1));
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_rd_en = enable & ~cmd_empty & rst_b;
                if (cmd_rd_en) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (op == OP_WAIT && arg_ticks != '0) ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (pre_wrap && last_tick) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Flush wins from any state; a fetched word is simply dropped.
        if (!enable) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd_reg   <= '0;
            period    <= '0;
            gain      <= 8'hFF;
            note_on   <= 1'b0;
            note_off  <= 1'b0;
            gate      <= 1'b0;
            err_count <= '0;
            tick_cnt  <= '0;
            pre_cnt   <= '0;
        end else begin
            note_on  <= 1'b0;
            note_off <= 1'b0;
            if (!enable) begin
                tick_cnt <= '0;
                pre_cnt  <= '0;
                if (gate) begin
                    gate     <= 1'b0;
                    note_off <= 1'b1;
                end
            end else begin
                case (state)
                    S_FETCH: cmd_reg <= cmd_data;
                    S_EXEC: begin
                        case (op)
                            OP_NOP: ;
                            OP_NOTE_ON: begin
                                if (arg_period != '0) begin
                                    period  <= arg_period;
                                    gate    <= 1'b1;
                                    note_on <= 1'b1;
                                end else if (gate) begin
                                    gate     <= 1'b0;
                                    note_off <= 1'b1;
                                end
                            end
                            OP_NOTE_OFF: begin
                                // Period is left alone so the release tail keeps sounding.
                                if (gate) begin
                                    gate     <= 1'b0;
                                    note_off <= 1'b1;
                                end
                            end
                            OP_WAIT: begin
                                if (arg_ticks != '0) begin
                                    tick_cnt <= arg_ticks;
                                    pre_cnt  <= '0;
                                end
                            end
                            OP_SET_GAIN: gain <= cmd_reg[7:0];
                            default: begin
                                if (err_count != 8'hFF) begin
                                    err_count <= err_count + 8'd1;
                                end
                            end
                        endcase
                    end
                    S_WAIT: begin
                        if (pre_wrap) begin
                            pre_cnt  <= '0;
                            tick_cnt <= tick_cnt - WAIT_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_cmd_sequencer.sv
// Bench for note_cmd_sequencer: a FIFO model feeds commands, a reference model predicts output
// changes and their cycles, and a monitor compares every observed output change and timed probe.
module tb_note_cmd_sequencer;

    localparam int TD = 4;

    localparam int SIG_RDEN   = 0;
    localparam int SIG_BUSY   = 1;
    localparam int SIG_PERIOD = 2;
    localparam int SIG_GAIN   = 3;
    localparam int SIG_GATE   = 4;
    localparam int SIG_ERR    = 5;

    logic        clk;
    logic        rst_b;
    logic        enable;
    logic        cmd_empty;
    logic        cmd_rd_en;
    logic [31:0] cmd_data;
    logic [22:0] period;
    logic [7:0]  gain;
    logic        note_on;
    logic        note_off;
    logic        gate;
    logic        busy;
    logic [7:0]  err_count;

    note_cmd_sequencer #(.TICK_DIV(TD), .PERIOD_W(23), .WAIT_W(24)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .enable    (enable),
        .cmd_empty (cmd_empty),
        .cmd_rd_en (cmd_rd_en),
        .cmd_data  (cmd_data),
        .period    (period),
        .gain      (gain),
        .note_on   (note_on),
        .note_off  (note_off),
        .gate      (gate),
        .busy      (busy),
        .err_count (err_count)
    );

    typedef struct {
        int          cyc;
        bit          on;
        bit          off;
        logic [22:0] per;
        logic [7:0]  gn;
        bit          gt;
        logic [7:0]  er;
    } ev_t;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } probe_t;

    ev_t         ev_q[$];
    probe_t      pr_q[$];
    logic [31:0] fifo[$];
    logic [31:0] batch[$];

    int cyc   = 0;
    bit done  = 0;
    int total = 0;
    int bad   = 0;

    logic [22:0] m_per;
    logic [7:0]  m_gain;
    logic [7:0]  m_err;
    bit          m_gate;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic model_reset();
        m_per  = '0;
        m_gain = 8'hFF;
        m_err  = '0;
        m_gate = 0;
    endtask

    // Predict the effect of one command popped at cycle t; t advances to the next pop opportunity.
    task automatic expect_cmd(input logic [31:0] w, inout int t);
        bit on = 0;
        bit off = 0;
        bit fire = 0;
        case (w[31:28])
            4'h0: ;
            4'h1: begin
                if (w[22:0] != 0) begin
                    m_per = w[22:0]; m_gate = 1; on = 1; fire = 1;
                end else if (m_gate) begin
                    m_gate = 0; off = 1; fire = 1;
                end
            end
            4'h2: if (m_gate) begin m_gate = 0; off = 1; fire = 1; end
            4'h3: ;
            4'h4: if (w[7:0] != m_gain) begin m_gain = w[7:0]; fire = 1; end
            default: if (m_err != 8'd255) begin m_err = m_err + 8'd1; fire = 1; end
        endcase
        if (fire) ev_q.push_back('{t + 3, on, off, m_per, m_gain, m_gate, m_err});
        t = t + 3 + ((w[31:28] == 4'h3) ? int'(w[23:0]) * TD : 0);
    endtask

    task automatic add_probe(input int c, input int s, input int v);
        pr_q.push_back('{c, s, v});
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the FIFO model updated.
    task automatic step();
        bit will_pop;
        #6;
        will_pop = cmd_rd_en;
        @(posedge clk);
        #1;
        if (will_pop && fifo.size() > 0) begin
            cmd_data  = fifo.pop_front();
            cmd_empty = (fifo.size() == 0);
        end
    endtask

    task automatic settle(input int end_c);
        int g = 0;
        while (cyc < end_c) step();
        while ((busy === 1'b1 || fifo.size() != 0) && g < 500) begin
            step();
            g++;
        end
        add_probe(cyc, SIG_BUSY, 0);
    endtask

    task automatic issue(input bit wait_idle);
        int t = cyc;
        int first = cyc;
        foreach (batch[i]) begin
            fifo.push_back(batch[i]);
            expect_cmd(batch[i], t);
        end
        cmd_empty = (fifo.size() == 0);
        add_probe(first, SIG_RDEN, 1);
        add_probe(first + 1, SIG_BUSY, 1);
        batch.delete();
        if (wait_idle) settle(t + 1);
    endtask

    function automatic logic [31:0] rand_cmd();
        int k = $urandom_range(0, 9);
        logic [27:0] a = 28'($urandom);
        case (k)
            0:       return {4'h0, a};
            1, 2:    return {4'h1, a[27:16], 16'($urandom_range(1, 4000))};
            3:       return {4'h1, a[27:23], 23'd0};
            4, 5:    return {4'h2, a};
            6:       return {4'h3, a[27:24], 24'($urandom_range(0, 3))};
            7:       return {4'h4, a};
            default: return {4'($urandom_range(5, 15)), a};
        endcase
    endfunction

    // Driver
    initial begin
        int k;
        int t;
        logic [31:0] w;
        rst_b = 1'b0; enable = 1'b1; cmd_empty = 1'b1; cmd_data = '0;
        model_reset();

        // Reset with a NOTE_ON already waiting in the FIFO
        fifo.push_back(32'h1000_1F40);
        cmd_empty = 1'b0;
        @(posedge clk); #1;
        step();
        add_probe(cyc, SIG_RDEN, 0);
        add_probe(cyc, SIG_PERIOD, 0);
        add_probe(cyc, SIG_GAIN, 255);
        add_probe(cyc, SIG_GATE, 0);
        add_probe(cyc, SIG_ERR, 0);
        add_probe(cyc, SIG_BUSY, 0);
        step();
        rst_b = 1'b1;
        t = cyc;
        add_probe(cyc, SIG_RDEN, 1);
        expect_cmd(32'h1000_1F40, t);
        settle(t + 1);

        // Back-to-back retrigger
        batch = '{32'h1000_0064, 32'h1000_00C8};
        issue(1);

        // NOTE_ON, WAIT 3 ticks, NOTE_OFF
        batch = '{32'h1000_0100, 32'h3000_0003, 32'h2000_0000};
        issue(1);
        add_probe(cyc, SIG_PERIOD, 256);

        // NOTE_OFF with gate low, then NOTE_ON period 0 with gate high
        batch = '{32'h2000_0000, 32'h1000_0005, 32'h1F80_0000};
        issue(1);

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 20; i++) batch.push_back(rand_cmd());
            issue(1);
        end

        // Illegal opcodes until err_count saturates
        for (int i = 0; i < 300; i++) batch.push_back(32'hF000_0000);
        issue(1);
        add_probe(cyc, SIG_ERR, 255);

        // Flush during WAIT with gate high
        batch = '{32'h1000_0200, 32'h3000_000A};
        issue(0);
        for (int i = 0; i < 15; i++) step();
        enable = 1'b0;
        k = cyc;
        m_gate = 0;
        ev_q.push_back('{k + 1, 1'b0, 1'b1, m_per, m_gain, 1'b0, m_err});
        add_probe(k + 1, SIG_BUSY, 0);
        for (int i = 1; i <= 5; i++) add_probe(k + i, SIG_RDEN, 0);
        step();
        w = 32'h4000_0011;
        fifo.push_back(w);
        cmd_empty = 1'b0;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b1;
        t = cyc;
        add_probe(cyc, SIG_RDEN, 1);
        expect_cmd(w, t);
        settle(t + 1);

        // Reset asserted mid-WAIT with a word pending
        batch = '{32'h1000_0033, 32'h3000_0005};
        issue(0);
        for (int i = 0; i < 10; i++) step();
        w = 32'h4000_0077;
        fifo.push_back(w);
        cmd_empty = 1'b0;
        step();
        rst_b = 1'b0;
        model_reset();
        add_probe(cyc, SIG_PERIOD, 0);
        add_probe(cyc, SIG_GAIN, 255);
        add_probe(cyc, SIG_GATE, 0);
        add_probe(cyc, SIG_ERR, 0);
        add_probe(cyc, SIG_BUSY, 0);
        add_probe(cyc, SIG_RDEN, 0);
        add_probe(cyc + 1, SIG_RDEN, 0);
        step();
        step();
        rst_b = 1'b1;
        t = cyc;
        add_probe(cyc, SIG_RDEN, 1);
        expect_cmd(w, t);
        settle(t + 1);

        step();
        done = 1;
    end

    function automatic int sig_val(input int s);
        case (s)
            SIG_RDEN:   return int'(cmd_rd_en);
            SIG_BUSY:   return int'(busy);
            SIG_PERIOD: return int'(period);
            SIG_GAIN:   return int'(gain);
            SIG_GATE:   return int'(gate);
            default:    return int'(err_count);
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_RDEN:   return "cmd_rd_en";
            SIG_BUSY:   return "busy";
            SIG_PERIOD: return "period";
            SIG_GAIN:   return "gain";
            SIG_GATE:   return "gate";
            default:    return "err_count";
        endcase
    endfunction

    // Monitor
    initial begin
        probe_t      p;
        ev_t         e;
        int          act;
        bit          trig;
        logic [22:0] p_per  = '0;
        logic [7:0]  p_gain = 8'hFF;
        logic [7:0]  p_err  = '0;
        logic        p_gate = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                total++;
                if (ev_q.size() != 0 || pr_q.size() != 0) begin
                    bad++;
                    $display("FAIL leftover: events=%0d probes=%0d required 0", ev_q.size(), pr_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
                p = pr_q.pop_front();
                act = sig_val(p.sig);
                total++;
                if (p.cyc != cyc || act != p.val) begin
                    bad++;
                    $display("FAIL probe %s @%0d: got %0d required %0d (seen @%0d)",
                             sig_name(p.sig), p.cyc, act, p.val, cyc);
                end
            end
            if (rst_b === 1'b1) begin
                trig = (note_on !== 1'b0) || (note_off !== 1'b0) || (period !== p_per) ||
                       (gain !== p_gain) || (gate !== p_gate) || (err_count !== p_err);
                if (trig) begin
                    total++;
                    if (ev_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected change @%0d: on=%b off=%b per=%0d gain=%0d gate=%b err=%0d required none",
                                 cyc, note_on, note_off, period, gain, gate, err_count);
                    end else begin
                        e = ev_q.pop_front();
                        if (e.cyc != cyc || note_on !== e.on || note_off !== e.off || period !== e.per ||
                            gain !== e.gn || gate !== e.gt || err_count !== e.er) begin
                            bad++;
                            $display("FAIL event @%0d: got on=%b off=%b per=%0d gain=%0d gate=%b err=%0d required @%0d on=%b off=%b per=%0d gain=%0d gate=%b err=%0d",
                                     cyc, note_on, note_off, period, gain, gate, err_count,
                                     e.cyc, e.on, e.off, e.per, e.gn, e.gt, e.er);
                        end
                    end
                end
                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    e = ev_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing event: required @%0d on=%b off=%b per=%0d gain=%0d gate=%b err=%0d, got nothing",
                             e.cyc, e.on, e.off, e.per, e.gn, e.gt, e.er);
                end
            end
            p_per  = period;
            p_gain = gain;
            p_err  = err_count;
            p_gate = gate;
        end
    end

endmodule
